// File: rtl/alu_ctrl_decoder.sv
// alu_ctrl_decoder: RV32I execute-stage ALU control decoder with a one-entry
// ID/EX register (valid/ready, stall, flush) and a saturating illegal counter.
module alu_ctrl_decoder #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic             CLK,
    input  logic             RESETN,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [31:0]      INSTR,
    input  logic [XLEN-1:0]  PC_IN,
    input  logic             FLUSH,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [2:0]       SELECT,
    output logic             ROTATE,
    output logic             NEG_DATA2,
    output logic [1:0]       OP1_SEL,
    output logic             IMM_SEL,
    output logic [XLEN-1:0]  IMM,
    output logic [XLEN-1:0]  PC_OUT,
    output logic             ILLEGAL,
    output logic [CNT_W-1:0] ILLEGAL_COUNT
);
    localparam logic [6:0] OP_REG = 7'b0110011, OP_IMM = 7'b0010011, OP_LUI = 7'b0110111,
                           OP_AUIPC = 7'b0010111, OP_LOAD = 7'b0000011, OP_STORE = 7'b0100011,
                           OP_BRANCH = 7'b1100011, OP_JAL = 7'b1101111, OP_JALR = 7'b1100111;
    localparam logic [6:0] F7_ALT = 7'b0100000;

    logic [6:0] opcode, f7;
    logic [2:0] f3, sel;
    logic [1:0] op1;
    logic rot, neg, isel, ill, cap;
    logic [XLEN-1:0] imm;

    assign opcode   = INSTR[6:0];
    assign f3       = INSTR[14:12];
    assign f7       = INSTR[31:25];
    assign IN_READY = ~OUT_VALID | OUT_READY;
    assign cap      = IN_VALID & IN_READY & ~FLUSH;

    always_comb begin
        sel  = 3'd0;
        rot  = 1'b0;
        neg  = 1'b0;
        op1  = 2'd0;
        isel = 1'b0;
        imm  = '0;
        ill  = 1'b0;
        case (opcode)
            OP_REG: begin
                sel = f3;
                neg = f7 == F7_ALT && f3 == 3'd0;
                rot = f7 == F7_ALT && f3 == 3'd5;
                ill = !(f7 == 7'd0 || neg || rot);
            end
            OP_IMM: begin
                sel  = f3;
                isel = 1'b1;
                // shift-immediates carry shamt only; the upper bits are the funct7 field
                imm  = (f3 == 3'd1 || f3 == 3'd5) ? XLEN'(INSTR[24:20]) : XLEN'($signed(INSTR[31:20]));
                rot  = f3 == 3'd5 && INSTR[30];
                ill  = (f3 == 3'd1 && f7 != 7'd0) || (f3 == 3'd5 && f7 != 7'd0 && f7 != F7_ALT);
            end
            OP_LUI, OP_AUIPC: begin
                op1  = opcode == OP_LUI ? 2'd2 : 2'd1;
                isel = 1'b1;
                imm  = XLEN'({INSTR[31:12], 12'b0});
            end
            OP_LOAD: begin
                isel = 1'b1;
                imm  = XLEN'($signed(INSTR[31:20]));
            end
            OP_STORE: begin
                isel = 1'b1;
                imm  = XLEN'($signed({INSTR[31:25], INSTR[11:7]}));
            end
            OP_BRANCH: begin
                sel = f3[2] ? (f3[1] ? 3'd3 : 3'd2) : 3'd0;
                neg = ~f3[2];
                ill = f3[2:1] == 2'b01;
            end
            OP_JAL, OP_JALR: begin
                op1  = 2'd1;
                isel = 1'b1;
                imm  = XLEN'(4);
                ill  = opcode == OP_JALR && f3 != 3'd0;
            end
            default: ill = 1'b1;
        endcase
        if (ill) begin
            sel  = 3'd0;
            rot  = 1'b0;
            neg  = 1'b0;
            op1  = 2'd0;
            isel = 1'b0;
            imm  = '0;
        end
    end

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            OUT_VALID     <= 1'b0;
            SELECT        <= 3'd0;
            ROTATE        <= 1'b0;
            NEG_DATA2     <= 1'b0;
            OP1_SEL       <= 2'd0;
            IMM_SEL       <= 1'b0;
            IMM           <= '0;
            PC_OUT        <= '0;
            ILLEGAL       <= 1'b0;
            ILLEGAL_COUNT <= '0;
        end else if (FLUSH) begin
            OUT_VALID <= 1'b0;
        end else if (cap) begin
            OUT_VALID <= 1'b1;
            SELECT    <= sel;
            ROTATE    <= rot;
            NEG_DATA2 <= neg;
            OP1_SEL   <= op1;
            IMM_SEL   <= isel;
            IMM       <= imm;
            PC_OUT    <= PC_IN;
            ILLEGAL   <= ill;
            if (ill && !(&ILLEGAL_COUNT))
                ILLEGAL_COUNT <= ILLEGAL_COUNT + 1'b1;
        end else if (OUT_READY) begin
            OUT_VALID <= 1'b0;
        end
    end
endmodule

// File: tb/tb_alu_ctrl_decoder.sv
// tb_alu_ctrl_decoder: scoreboard bench for alu_ctrl_decoder (CNT_W=4 so the
// illegal counter saturation is reachable quickly).
module tb_alu_ctrl_decoder;
    typedef struct packed {
        logic [2:0]  sel;
        logic        rot;
        logic        neg;
        logic [1:0]  op1;
        logic        isel;
        logic        ill;
        logic [31:0] imm;
        logic [31:0] pc;
    } exp_t;

    logic clk = 1'b0, rst_n = 1'b1;
    logic in_valid = 1'b0, flush = 1'b0, out_ready = 1'b1;
    logic [31:0] instr = '0, pc_in = '0;
    logic in_ready, out_valid, rotate, neg_data2, imm_sel, illegal;
    logic [2:0] select;
    logic [1:0] op1_sel;
    logic [31:0] imm, pc_out;
    logic [3:0] illegal_count;

    int total = 0, bad = 0, exp_cnt = 0;
    logic [31:0] pc = 32'h1000;
    exp_t sb[$];
    exp_t last;

    alu_ctrl_decoder #(.XLEN(32), .CNT_W(4)) dut (
        .CLK(clk), .RESETN(rst_n), .IN_VALID(in_valid), .IN_READY(in_ready),
        .INSTR(instr), .PC_IN(pc_in), .FLUSH(flush), .OUT_VALID(out_valid),
        .OUT_READY(out_ready), .SELECT(select), .ROTATE(rotate), .NEG_DATA2(neg_data2),
        .OP1_SEL(op1_sel), .IMM_SEL(imm_sel), .IMM(imm), .PC_OUT(pc_out),
        .ILLEGAL(illegal), .ILLEGAL_COUNT(illegal_count)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached before end of test");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic check_fields(input string tag, input exp_t e);
        check({tag, ".sel"}, 64'(select), 64'(e.sel));
        check({tag, ".rot"}, 64'(rotate), 64'(e.rot));
        check({tag, ".neg"}, 64'(neg_data2), 64'(e.neg));
        check({tag, ".op1"}, 64'(op1_sel), 64'(e.op1));
        check({tag, ".isel"}, 64'(imm_sel), 64'(e.isel));
        check({tag, ".ill"}, 64'(illegal), 64'(e.ill));
        check({tag, ".imm"}, 64'(imm), 64'(e.imm));
        check({tag, ".pc"}, 64'(pc_out), 64'(e.pc));
    endtask

    task automatic drain(input string tag);
        check({tag, ".vld"}, 64'(out_valid), 64'd1);
        if (sb.size() == 0) begin
            check({tag, ".sb_empty"}, 64'd1, 64'd0);
        end else begin
            last = sb.pop_front();
            check_fields(tag, last);
        end
        check({tag, ".cnt"}, 64'(illegal_count), 64'(exp_cnt));
    endtask

    // drive one instruction, push its expectation, capture on the next edge and compare
    task automatic send(input string tag, input logic [31:0] ins, input logic [2:0] s,
                        input logic r, input logic n, input logic [1:0] o, input logic i,
                        input logic l, input logic [31:0] im);
        in_valid = 1'b1;
        instr    = ins;
        pc_in    = pc;
        sb.push_back('{s, r, n, o, i, l, im, pc});
        if (l) exp_cnt = exp_cnt == 15 ? 15 : exp_cnt + 1;
        @(posedge clk);
        #1;
        pc = pc + 4;
        drain(tag);
    endtask

    initial begin
        #2 rst_n = 1'b0;
        #1;
        check("rst.vld", 64'(out_valid), 64'd0);
        check("rst.rdy", 64'(in_ready), 64'd1);
        check("rst.cnt", 64'(illegal_count), 64'd0);
        check_fields("rst", '0);
        @(negedge clk) rst_n = 1'b1;

        // flushed capture of an illegal word must not count
        in_valid = 1'b1; instr = 32'h0; flush = 1'b1;
        @(posedge clk); #1;
        check("flush.vld", 64'(out_valid), 64'd0);
        check("flush.cnt", 64'(illegal_count), 64'd0);
        flush = 1'b0;

        send("sub",   32'h40B50533, 3'd0, 0, 1, 2'd0, 0, 0, 32'h0);
        send("srai",  32'h40355513, 3'd5, 1, 0, 2'd0, 1, 0, 32'h3);
        send("addi",  32'hFFF00513, 3'd0, 0, 0, 2'd0, 1, 0, 32'hFFFFFFFF);
        send("lui",   32'h12345537, 3'd0, 0, 0, 2'd2, 1, 0, 32'h12345000);
        send("bltu",  32'h00B56463, 3'd3, 0, 0, 2'd0, 0, 0, 32'h0);
        send("auipc", 32'h00000297, 3'd0, 0, 0, 2'd1, 1, 0, 32'h0);
        send("jal",   32'h0000006F, 3'd0, 0, 0, 2'd1, 1, 0, 32'h4);
        send("jalr",  32'h00008067, 3'd0, 0, 0, 2'd1, 1, 0, 32'h4);
        send("jalrf3",32'h00009067, 3'd0, 0, 0, 2'd0, 0, 1, 32'h0);
        send("sw",    32'h00A12223, 3'd0, 0, 0, 2'd0, 1, 0, 32'h4);
        send("lw",    32'hFFC52503, 3'd0, 0, 0, 2'd0, 1, 0, 32'hFFFFFFFC);
        send("beq",   32'h00B50463, 3'd0, 0, 1, 2'd0, 0, 0, 32'h0);
        send("slt",   32'h00B52533, 3'd2, 0, 0, 2'd0, 0, 0, 32'h0);
        send("sra",   32'h40B55533, 3'd5, 1, 0, 2'd0, 0, 0, 32'h0);
        send("slli7", 32'h40151513, 3'd0, 0, 0, 2'd0, 0, 1, 32'h0);
        send("xor7",  32'h40B54533, 3'd0, 0, 0, 2'd0, 0, 1, 32'h0);
        send("br2",   32'h00B52463, 3'd0, 0, 0, 2'd0, 0, 1, 32'h0);
        send("andi",  32'h0FF57513, 3'd7, 0, 0, 2'd0, 1, 0, 32'h000000FF);

        // stall: entry held, new instruction waiting, nothing moves
        out_ready = 1'b0;
        instr = 32'h00B57533;
        pc_in = pc;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            check("stall.rdy", 64'(in_ready), 64'd0);
            check("stall.vld", 64'(out_valid), 64'd1);
            check_fields("stall", last);
        end
        sb.push_back('{3'd7, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 32'h0, pc});
        out_ready = 1'b1;
        @(posedge clk); #1;
        pc = pc + 4;
        drain("unstall");
        in_valid = 1'b0;
        @(posedge clk); #1;
        check("drain.vld", 64'(out_valid), 64'd0);

        // flush of a held, stalled entry
        send("held", 32'h00B50533, 3'd0, 0, 0, 2'd0, 0, 0, 32'h0);
        in_valid = 1'b0; out_ready = 1'b0;
        @(posedge clk); #1;
        check("held.vld", 64'(out_valid), 64'd1);
        flush = 1'b1;
        @(posedge clk); #1;
        check("flushheld.vld", 64'(out_valid), 64'd0);
        flush = 1'b0; out_ready = 1'b1;

        for (int k = 0; k < 17; k++)
            send("illcnt", 32'h0, 3'd0, 0, 0, 2'd0, 0, 1, 32'h0);
        check("sat.cnt", 64'(illegal_count), 64'd15);

        // asynchronous reset mid-stream
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        check("arst.vld", 64'(out_valid), 64'd0);
        check("arst.cnt", 64'(illegal_count), 64'd0);
        check("arst.rdy", 64'(in_ready), 64'd1);
        check("arst.ill", 64'(illegal), 64'd0);
        sb.delete();
        in_valid = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        check("post.vld", 64'(out_valid), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
